// File: rtl/pci_cfg_target_if.sv
// pci_cfg_target_if: shared PCI bus signals between an initiator and the config target
interface pci_cfg_target_if;
  logic        pci_frame_n;
  logic        pci_irdy_n;
  logic        pci_idsel;
  logic [3:0]  pci_cbe_n;
  logic [31:0] pci_ad_in;
  logic [31:0] pci_ad_out;
  logic        pci_ad_oe;
  logic        pci_devsel_n;
  logic        pci_trdy_n;
  logic        pci_stop_n;
  modport master (
    output pci_frame_n, pci_irdy_n, pci_idsel, pci_cbe_n, pci_ad_in,
    input  pci_ad_out, pci_ad_oe, pci_devsel_n, pci_trdy_n, pci_stop_n
  );
  modport slave (
    input  pci_frame_n, pci_irdy_n, pci_idsel, pci_cbe_n, pci_ad_in,
    output pci_ad_out, pci_ad_oe, pci_devsel_n, pci_trdy_n, pci_stop_n
  );
endinterface

// File: rtl/pci_cfg_target.sv
// pci_cfg_target: Type-0 config target moving one dword per transaction into or out of a register file
module pci_cfg_target #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] VENDOR_ID   = 16'h1234,
  parameter logic [15:0] DEVICE_ID   = 16'hABCD
) (
  input logic pci_clk,
  input logic pci_rst_n,
  pci_cfg_target_if.slave bus
);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic [2:0] {IDLE, CLAIM, DATA, TURN, BUSY} state_t;
  state_t        state, state_nx;
  logic [IW-1:0] index;
  logic          wr;
  logic [2:0]    cnt;
  logic [31:0]   regs [NUM_REGS];
  logic          claim, xfer, oe;
  logic [31:0]   rdata;
  assign claim = bus.pci_idsel && (bus.pci_cbe_n == 4'hA || bus.pci_cbe_n == 4'hB) && bus.pci_ad_in[1:0] == 2'b00;
  assign xfer  = state == DATA && !bus.pci_irdy_n;
  assign rdata = index == '0 ? {DEVICE_ID, VENDOR_ID} : regs[index];
  assign oe    = state == DATA && !wr;
  assign bus.pci_ad_oe    = oe;
  assign bus.pci_ad_out   = oe ? rdata : '0;
  assign bus.pci_devsel_n = !(state == CLAIM || state == DATA);
  assign bus.pci_trdy_n   = state != DATA;
  assign bus.pci_stop_n   = !(state == DATA && !bus.pci_frame_n);
  // state register
  always_ff @(posedge pci_clk or negedge pci_rst_n)
    if (!pci_rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state decode; address phases are only decoded from IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.pci_frame_n ? IDLE : claim ? CLAIM : BUSY;
      CLAIM:   state_nx = cnt == '0 ? DATA : CLAIM;
      DATA:    state_nx = bus.pci_irdy_n ? DATA : TURN;
      TURN:    state_nx = (!bus.pci_frame_n || !bus.pci_irdy_n) ? BUSY : IDLE;
      BUSY:    state_nx = (bus.pci_frame_n && bus.pci_irdy_n) ? IDLE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  // latch index, direction and wait count on a claimed address phase
  always_ff @(posedge pci_clk or negedge pci_rst_n)
    if (!pci_rst_n) begin
      index <= '0;
      wr    <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && !bus.pci_frame_n && claim) begin
      index <= bus.pci_ad_in[2+:IW];
      wr    <= bus.pci_cbe_n[0];
      cnt   <= 3'(WAIT_STATES);
    end else if (state == CLAIM && cnt != '0) cnt <= cnt - 3'd1;
  // byte-enabled write on transfer; dword 0 is the read-only ID and never stored
  always_ff @(posedge pci_clk or negedge pci_rst_n)
    if (!pci_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (xfer && wr && index != '0) begin
      for (int b = 0; b < 4; b++)
        if (!bus.pci_cbe_n[b]) regs[index][8*b+:8] <= bus.pci_ad_in[8*b+:8];
    end
endmodule

// File: tb/tb_pci_cfg_target.sv
// tb_pci_cfg_target: scoreboarded config read/write checks on a zero- and a two-wait-state target
module tb_pci_cfg_target;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pci_cfg_target_if b0();
  pci_cfg_target_if b2();
  logic        sel, frame_n, irdy_n, idsel;
  logic [3:0]  cbe_n;
  logic [31:0] ad;
  assign b0.pci_frame_n = frame_n;
  assign b0.pci_irdy_n  = irdy_n;
  assign b0.pci_idsel   = idsel & !sel;
  assign b0.pci_cbe_n   = cbe_n;
  assign b0.pci_ad_in   = ad;
  assign b2.pci_frame_n = frame_n;
  assign b2.pci_irdy_n  = irdy_n;
  assign b2.pci_idsel   = idsel & sel;
  assign b2.pci_cbe_n   = cbe_n;
  assign b2.pci_ad_in   = ad;
  pci_cfg_target #(.WAIT_STATES(0)) u0 (.pci_clk(clk), .pci_rst_n(rst_n), .bus(b0));
  pci_cfg_target #(.WAIT_STATES(2)) u2 (.pci_clk(clk), .pci_rst_n(rst_n), .bus(b2));
  logic        devsel_n, trdy_n, stop_n, ad_oe;
  logic [31:0] ad_out;
  assign devsel_n = sel ? b2.pci_devsel_n : b0.pci_devsel_n;
  assign trdy_n   = sel ? b2.pci_trdy_n   : b0.pci_trdy_n;
  assign stop_n   = sel ? b2.pci_stop_n   : b0.pci_stop_n;
  assign ad_oe    = sel ? b2.pci_ad_oe    : b0.pci_ad_oe;
  assign ad_out   = sel ? b2.pci_ad_out   : b0.pci_ad_out;
  int nvec = 0;
  int nbad = 0;
  logic [31:0] sb [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // read data is scored when a read transfer is seen on the bus
  always @(negedge clk)
    if (rst_n && !trdy_n && !irdy_n && ad_oe) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("rd_data", ad_out, sb.pop_front());
    end
  task automatic xact(input bit s, input bit id, input logic [3:0] cmd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input bit claim, input bit burst,
                      input bit th, input int hold, input int ws, input logic [31:0] exp);
    bit rd = cmd == 4'hA;
    bit done = 1'b0;
    int cyc = 0;
    int first = 0;
    sel = s; frame_n = 1'b0; irdy_n = 1'b1; idsel = id; cbe_n = cmd; ad = addr;
    if (claim && rd) sb.push_back(exp);
    @(posedge clk); #1;
    if (!claim) begin
      idsel = 1'b0; cbe_n = 4'h0; ad = 32'h0; irdy_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_devsel", devsel_n, 1);
        @(posedge clk); #1;
        if (i == 0) begin idsel = 1'b1; cbe_n = 4'hA; ad = 32'h0; end
      end
      frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0;
      @(posedge clk); #1;
    end else begin
      idsel = 1'b0; cbe_n = be; ad = rd ? 32'h0 : wd; frame_n = !burst; irdy_n = hold > 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          check("devsel_c1", devsel_n, 0);
          check("oe_claim", ad_oe, 0);
          check("adout_claim", ad_out, 0);
        end
        if (!trdy_n) begin
          if (first == 0) begin
            first = cyc;
            check("trdy_lat", first, 2 + ws);
            check("oe_data", ad_oe, rd);
          end
          check("stop", stop_n, !burst);
          if (irdy_n) begin
            check("rd_hold", ad_out, rd ? exp : 32'h0);
            hold--;
          end else done = 1'b1;
        end
        @(posedge clk); #1;
        if (done && th) begin frame_n = 1'b0; irdy_n = 1'b1; idsel = 1'b1; cbe_n = 4'hA; ad = 32'h0; end
        else if (done) begin frame_n = 1'b1; irdy_n = !burst; ad = ~wd; cbe_n = 4'h0; end
        else if (hold == 0) irdy_n = 1'b0;
      end
      check("xfer_done", done, 1);
      @(negedge clk);
      check("turn_devsel", devsel_n, 1);
      check("turn_trdy", trdy_n, 1);
      check("turn_stop", stop_n, 1);
      check("turn_oe", ad_oe, 0);
      check("turn_adout", ad_out, 0);
      @(posedge clk); #1;
      irdy_n = 1'b1; idsel = 1'b0;
      if (th) begin
        repeat (2) begin
          @(negedge clk);
          check("turn_addr_ignored", devsel_n, 1);
        end
        @(posedge clk); #1;
        frame_n = 1'b1;
      end
      @(negedge clk);
      check("idle_after", devsel_n, 1);
      @(posedge clk); #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    sel = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cbe_n = 4'hF; ad = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_devsel", devsel_n, 1);
    check("rst_trdy", trdy_n, 1);
    check("rst_stop", stop_n, 1);
    check("rst_oe", ad_oe, 0);
    check("rst_adout", ad_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1, 4'hA, 32'h00, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'hABCD1234);
    xact(0, 1, 4'hB, 32'h0C, 32'hDEADBEEF, 4'b0101, 1, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h0C, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'hDE00BE00);
    xact(1, 1, 4'hB, 32'h04, 32'h12345678, 4'h0, 1, 0, 0, 0, 2, 32'h0);
    xact(1, 1, 4'hA, 32'h04, 32'h0, 4'h0, 1, 0, 0, 3, 2, 32'h12345678);
    xact(0, 0, 4'hA, 32'h00, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'h6, 32'h00, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h01, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hB, 32'h08, 32'hCAFEF00D, 4'h0, 1, 1, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h08, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'hCAFEF00D);
    xact(0, 1, 4'hB, 32'h00, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h00, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'hABCD1234);
    xact(0, 1, 4'hA, 32'h0C, 32'h0, 4'h0, 1, 0, 1, 0, 0, 32'hDE00BE00);
    xact(0, 1, 4'hB, 32'h3C, 32'h0BADF00D, 4'h0, 1, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h3C, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'h0BADF00D);
    xact(0, 1, 4'hA, 32'h4C, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'hDE00BE00);
    xact(0, 1, 4'hA, 32'h08, 32'h0, 4'h0, 1, 0, 0, 2, 0, 32'hCAFEF00D);
    sel = 1'b0; frame_n = 1'b0; irdy_n = 1'b1; idsel = 1'b1; cbe_n = 4'hB; ad = 32'h14;
    @(posedge clk); #1;
    idsel = 1'b0; frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad = 32'h5555AAAA;
    #1 check("pre_rst_devsel", devsel_n, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_devsel", devsel_n, 1);
    check("async_rst_oe", ad_oe, 0);
    irdy_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1, 4'hA, 32'h14, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'h0);
    xact(0, 1, 4'hA, 32'h0C, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'h0);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/pci_cfg_target.md
Name: pci_cfg_target

Overview:
- PCI configuration-space target: the responder end of the initiator-side config read/write transactions driven from the DPI task layer.
- Decodes Type-0 config read/write cycles, claims them with DEVSEL#, and moves one dword per transaction into or out of a small register file.
- Sits on the shared PCI bus signals as the device under test for C-driven config accesses. The AD bus is split into in/out/output-enable.

Parameters:
- NUM_REGS, 16: number of 32-bit config dwords; power of 2, 2..64.
- WAIT_STATES, 0: extra cycles between DEVSEL# assertion and TRDY# assertion, 0..7.
- VENDOR_ID, 16'h1234: read-only value in dword 0 [15:0].
- DEVICE_ID, 16'hABCD: read-only value in dword 0 [31:16].

Ports:
- pci_clk  in  1  bus clock; all sampling on the rising edge.
- pci_rst_n  in  1  asynchronous active-low reset.
- pci_frame_n  in  1  FRAME#, active-low.
- pci_irdy_n  in  1  IRDY#, active-low.
- pci_idsel  in  1  IDSEL, active-high.
- pci_cbe_n  in  4  command during the address phase; active-low byte enables during the data phase.
- pci_ad_in  in  32  AD as sampled.
- pci_ad_out  out  32  AD driven by the target.
- pci_ad_oe  out  1  1 = target drives AD.
- pci_devsel_n  out  1  DEVSEL#.
- pci_trdy_n  out  1  TRDY#.
- pci_stop_n  out  1  STOP#.

Behaviour:
- Reset (asynchronous, pci_rst_n=0): state IDLE; devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0, ad_out=0; RW registers cleared to 0.
- States: IDLE, CLAIM, DATA, TURN, BUSY.

IDLE:
- Address phase is the edge where frame_n=0.
- Claim when all hold: idsel=1, cbe_n=4'hA (cfg read) or 4'hB (cfg write), ad_in[1:0]=2'b00.
- On claim: latch index = ad_in[2+:log2(NUM_REGS)], direction, and wait counter = WAIT_STATES; go to CLAIM.
- Any other frame_n=0 sample: go to BUSY.

BUSY:
- Outputs stay idle.
- Return to IDLE on the edge where frame_n=1 and irdy_n=1.

CLAIM:
- devsel_n=0.
- This cycle is the read turnaround, so ad_oe=0 here.
- If counter=0, go to DATA; otherwise decrement and stay.
- Latency: trdy_n first 0 in cycle 2+WAIT_STATES after the address edge; devsel_n is 0 from cycle 1.

DATA:
- devsel_n=0, trdy_n=0.
- Read: ad_oe=1 and ad_out=reg[index], holding stable until transfer; byte enables are ignored on reads.
- stop_n=0 if frame_n=0 (burst attempt): disconnect-with-data, exactly one dword per transaction.
- Transfer occurs on the edge where irdy_n=0 and trdy_n=0.
- Write on transfer: for each i with cbe_n[i]=0, reg[index][8i+:8] <= ad_in[8i+:8].
- Dword 0 is read-only and writes to it are discarded; it always reads {DEVICE_ID, VENDOR_ID}.
- After transfer go to TURN. While irdy_n=1, hold all outputs.

TURN:
- One cycle; devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0.
- Next state is BUSY if frame_n=0 or irdy_n=0, else IDLE.

Boundary conditions:
- Index at or above NUM_REGS is impossible: the width is truncated by construction.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronous); a partial write is never committed.
- A frame_n=0 sample during TURN is not decoded as an address phase; it routes to BUSY.
- Back-to-back transactions: the next address phase is accepted no earlier than the first IDLE cycle.
- ad_out is 0 whenever ad_oe=0.

Test Plan:
- Reset, then cfg read (cbe_n=A, idsel=1, ad=0x00), irdy_n=0 throughout -> devsel_n=0 at cycle 1; trdy_n=0 and ad_oe=1 at cycle 2; ad_out=0xABCD1234; all outputs idle at cycle 4.
- Cfg write index 3 (ad=0x0C, cbe_n=B), data 0xDEADBEEF, byte enables cbe_n=4'b0101; then read index 3 -> read returns 0xDE00BE00.
- WAIT_STATES=2, cfg read index 1 with irdy_n held 1 for 3 cycles after trdy_n=0 -> trdy_n first low at cycle 4; ad_out stable; single transfer when irdy_n drops.
- Each of the following is ignored, with devsel_n staying 1 and the FSM in BUSY until frame_n=irdy_n=1:
  - idsel=0 with cbe_n=A;
  - idsel=1 with cbe_n=6 (memory read);
  - ad_in[1:0]=01.
- Burst write to index 2 with frame_n held 0 into the data phase -> stop_n=0 alongside trdy_n=0; only the first dword is written; reg 2 = first data word.
- Write to index 0 with data 0xFFFFFFFF -> read of index 0 still returns 0xABCD1234.
- Reset asserted in CLAIM of a write -> devsel_n=1 immediately; target register unchanged.
